// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, ALU and response signals of the shared-ALU arbiter.
interface alu_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_result;
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
           alu_result, alu_zero,
    input  req0_ready, req1_ready, alu_control, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
           alu_result, alu_zero,
    output req0_ready, req1_ready, alu_control, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters, mul held MUL_CYCLES.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module alu_arbiter #(
  parameter int MUL_CYCLES = 3,
  parameter int MAX_OP = 9
) (
  input logic clk,
  input logic rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic {IDLE, EXEC} state_t;
  localparam logic [3:0] MAX = 4'(MAX_OP);
  state_t state;
  logic pend_id, g0, g1, bad;
  logic [3:0] cnt, op;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign g0 = bus.req0_valid;
`else
  logic last_grant;
  assign g0 = bus.req0_valid & (~bus.req1_valid | last_grant);
`endif
  assign g1 = bus.req1_valid & ~g0;
  assign op = g1 ? bus.req1_op : bus.req0_op;
  assign bad = bus.alu_control > MAX;
  assign bus.req0_ready = (state == IDLE) & g0;
  assign bus.req1_ready = (state == IDLE) & g1;
  assign bus.busy = state == EXEC;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pend_id <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      bus.alu_control <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (state == IDLE && (g0 | g1)) begin
        bus.alu_control <= op;
        bus.alu_a <= g1 ? bus.req1_a : bus.req0_a;
        bus.alu_b <= g1 ? bus.req1_b : bus.req0_b;
        cnt <= (op == 4'd2) ? 4'(MUL_CYCLES - 1) : 4'd0;
        pend_id <= g1;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= g1;
`endif
        state <= EXEC;
      end else if (state == EXEC) begin
        if (cnt == 4'd0) begin
          state <= IDLE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_id <= pend_id;
          bus.rsp_result <= bad ? 32'd0 : bus.alu_result;
          bus.rsp_zero <= bad ? 1'b0 : bus.alu_zero;
          bus.rsp_err <= bad;
        end else
          cnt <= cnt - 4'd1;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random requests against a timeline model of grants and responses.
module tb_alu_arbiter;
  localparam int MC = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] res;
    logic        z;
    logic        e;
  } rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0, acc = -1, busy_until = 0;
  logic last_grant = 1'b1;
  rsp_t q[$];
  rsp_t last;
  logic [3:0] cur_op;
  logic [31:0] cur_a, cur_b;
  alu_arbiter_if bus();
  alu_arbiter #(.MUL_CYCLES(MC), .MAX_OP(9)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: alu_f = a + b;
      4'd1: alu_f = a - b;
      4'd2: alu_f = a * b;
      4'd3: alu_f = a & b;
      4'd4: alu_f = a | b;
      4'd5: alu_f = ~(a | b);
      4'd6: alu_f = a ^ b;
      4'd7: alu_f = a << b[4:0];
      4'd8: alu_f = a >> b[4:0];
      4'd9: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu_f = 32'hDEAD_BEEF;
    endcase
  endfunction
  assign bus.alu_result = alu_f(bus.alu_control, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = alu_f(bus.alu_control, bus.alu_a, bus.alu_b) == 32'd0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic model_reset();
    q.delete();
    busy_until = 0;
    acc = -1;
    last_grant = 1'b1;
    cur_op = '0;
    cur_a = '0;
    cur_b = '0;
    last = '{0, 1'b0, 32'd0, 1'b0, 1'b0};
  endtask
  task automatic set0(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = 1'b1; bus.req0_op = o; bus.req0_a = a; bus.req0_b = b;
  endtask
  task automatic set1(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = 1'b1; bus.req1_op = o; bus.req1_a = a; bus.req1_b = b;
  endtask
  // One clock of the reference timeline: the ALU is free once the previous op's response cycle arrives.
  task automatic step();
    logic idle, g0, g1, took, id;
    logic [3:0] op;
    logic [31:0] a, b, r;
    int l;
    @(negedge clk);
    idle = !(cyc > acc && cyc < busy_until);
    if (bus.req0_valid && bus.req1_valid) begin
      g0 = idle && (FIXED || last_grant);
      g1 = idle && !g0;
    end else begin
      g0 = idle && bus.req0_valid;
      g1 = idle && bus.req1_valid;
    end
    if (!rst) begin
      chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
    end
    chk("busy", 32'(bus.busy), 32'(!idle));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(q.size() != 0 && q[0].due == cyc));
    if (q.size() != 0 && q[0].due == cyc) last = q.pop_front();
    chk("rsp_id", 32'(bus.rsp_id), 32'(last.id));
    chk("rsp_result", bus.rsp_result, last.res);
    chk("rsp_zero", 32'(bus.rsp_zero), 32'(last.z));
    chk("rsp_err", 32'(bus.rsp_err), 32'(last.e));
    chk("alu_control", 32'(bus.alu_control), 32'(cur_op));
    chk("alu_a", bus.alu_a, cur_a);
    chk("alu_b", bus.alu_b, cur_b);
    took = !rst && (g0 || g1);
    id = g1;
    if (took) begin
      op = id ? bus.req1_op : bus.req0_op;
      a = id ? bus.req1_a : bus.req0_a;
      b = id ? bus.req1_b : bus.req0_b;
      l = (op == 4'd2) ? MC : 1;
      r = (op > 4'd9) ? 32'd0 : alu_f(op, a, b);
      q.push_back('{cyc + l + 1, id, r, (op <= 4'd9) && (r == 32'd0), op > 4'd9});
      acc = cyc;
      busy_until = cyc + l + 1;
      last_grant = id;
      cur_op = op; cur_a = a; cur_b = b;
    end
    @(posedge clk);
    if (rst) model_reset();
    #1;
    cyc++;
    if (took && !id) bus.req0_valid = 1'b0;
    if (took && id) bus.req1_valid = 1'b0;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  function automatic logic [31:0] rnd();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom());
  endfunction
  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    set0(4'd0, 32'd4, 32'd9);
    run(3);
    chk("add_result", bus.rsp_result, 32'd13);
    chk("add_id", 32'(bus.rsp_id), 32'd0);
    set1(4'd2, 32'd3, 32'd5);
    run(5);
    chk("mul_result", bus.rsp_result, 32'd15);
    chk("mul_id", 32'(bus.rsp_id), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (!bus.req0_valid) set0(4'd1, 32'd9, 32'd2);
      if (!bus.req1_valid) set1(4'd9, 32'd7, 32'd15);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    run(3);
    set0(4'd12, 32'd1, 32'd1);
    run(3);
    chk("illegal_err", 32'(bus.rsp_err), 32'd1);
    chk("illegal_result", bus.rsp_result, 32'd0);
    set0(4'd6, 32'h0000_FFFF, 32'h00FF_00FF);
    run(3);
    chk("xor_result", bus.rsp_result, 32'h00FF_FF00);
    chk("xor_err", 32'(bus.rsp_err), 32'd0);
    set0(4'd2, 32'd5, 32'd6);
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    run(3);
    set1(4'd0, 32'd0, 32'd0);
    run(3);
    chk("zero_result", bus.rsp_result, 32'd0);
    chk("zero_flag", 32'(bus.rsp_zero), 32'd1);
    chk("zero_id", 32'(bus.rsp_id), 32'd1);
    for (int i = 0; i < 600; i++) begin
      if (!bus.req0_valid && $urandom_range(0, 1) == 1) set0(4'($urandom_range(0, 15)), rnd(), rnd());
      if (!bus.req1_valid && $urandom_range(0, 1) == 1) set1(4'($urandom_range(0, 15)), rnd(), rnd());
      rst = $urandom_range(0, 99) == 0;
      step();
      rst = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
